// File: rtl/baud_tick_gen.sv
// Fractional baud-rate generator: oversample tick every D + F/2^FRAC_W
// cycles on average, bit tick every OVS oversample ticks, with run-time
// divisor load and a mid-bit re-phase strobe for receiver alignment.
module baud_tick_gen #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned FRAC_W   = 4,
  parameter int unsigned OVS      = 16,
  parameter int unsigned DIV_RST  = 40,
  parameter int unsigned FRAC_RST = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              sync,
  output logic              os_tick,
  output logic              bit_tick
);

  localparam int unsigned       OS_W     = (OVS > 2) ? $clog2(OVS) : 1;
  localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVS - 1);
  localparam logic [OS_W-1:0]   OS_MID   = OS_W'(OVS / 2);
  localparam logic [CNT_W-1:0]  D_MIN    = CNT_W'(2);
  localparam logic [CNT_W-1:0]  D_RST    = (DIV_RST < 2) ? D_MIN : CNT_W'(DIV_RST);
  localparam logic [FRAC_W-1:0] F_RST    = FRAC_W'(FRAC_RST);
  localparam logic [CNT_W:0]    CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};

  // Active divisor and phase state
  logic [CNT_W-1:0]  r_d;
  logic [FRAC_W-1:0] r_f;
  logic [CNT_W:0]    r_cnt;
  logic [CNT_W:0]    r_len;
  logic [FRAC_W-1:0] r_acc;
  logic [OS_W-1:0]   r_os_cnt;
  logic              r_os_tick;
  logic              r_bit_tick;

  // Period-start arithmetic, shared by load/sync restarts and tick wraps
  logic              w_restart;
  logic [CNT_W-1:0]  w_d_sel;
  logic [FRAC_W-1:0] w_f_sel;
  logic [FRAC_W-1:0] w_acc_base;
  logic [FRAC_W:0]   w_sum;
  logic [CNT_W:0]    w_len_next;
  logic [FRAC_W-1:0] w_acc_next;
  logic              w_wrap;

  // Select divisor/accumulator source and compute the next period length
  always_comb begin
    w_restart  = div_load | sync;
    w_d_sel    = r_d;
    w_f_sel    = r_f;
    w_acc_base = r_acc;
    if (div_load) begin
      w_d_sel = (div_int < D_MIN) ? D_MIN : div_int;
      w_f_sel = div_frac;
    end
    if (w_restart) begin
      w_acc_base = '0;
    end
    w_sum      = {1'b0, w_acc_base} + {1'b0, w_f_sel};
    w_len_next = {1'b0, w_d_sel} + {{CNT_W{1'b0}}, w_sum[FRAC_W]};
    w_acc_next = w_sum[FRAC_W-1:0];
    w_wrap     = (r_cnt == (r_len - CNT_ONE));
  end

  // Counter, accumulator, oversample counter and registered tick outputs.
  // len/acc always hold the already-started period, so reset preloads the
  // first period computed from acc=0 and the reset divisor.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d        <= D_RST;
      r_f        <= F_RST;
      r_cnt      <= '0;
      r_len      <= {1'b0, D_RST};
      r_acc      <= F_RST;
      r_os_cnt   <= '0;
      r_os_tick  <= 1'b0;
      r_bit_tick <= 1'b0;
    end else if (w_restart) begin
      r_d        <= w_d_sel;
      r_f        <= w_f_sel;
      r_cnt      <= '0;
      r_len      <= w_len_next;
      r_acc      <= w_acc_next;
      r_os_cnt   <= sync ? OS_MID : '0;
      r_os_tick  <= 1'b0;
      r_bit_tick <= 1'b0;
    end else if (en) begin
      if (w_wrap) begin
        r_cnt     <= '0;
        r_len     <= w_len_next;
        r_acc     <= w_acc_next;
        r_os_tick <= 1'b1;
        if (r_os_cnt == OS_LAST) begin
          r_os_cnt   <= '0;
          r_bit_tick <= 1'b1;
        end else begin
          r_os_cnt   <= r_os_cnt + 1'b1;
          r_bit_tick <= 1'b0;
        end
      end else begin
        r_cnt      <= r_cnt + CNT_ONE;
        r_os_tick  <= 1'b0;
        r_bit_tick <= 1'b0;
      end
    end else begin
      r_os_tick  <= 1'b0;
      r_bit_tick <= 1'b0;
    end
  end

  assign os_tick  = r_os_tick;
  assign bit_tick = r_bit_tick;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Testbench for baud_tick_gen: per-cycle comparison against a closed-form
// tick-time model plus scenario checks of periods and bit-tick latencies.
module tb_baud_tick_gen;

  localparam int CNT_W    = 16;
  localparam int FRAC_W   = 4;
  localparam int OVS      = 16;
  localparam int DIV_RST  = 40;
  localparam int FRAC_RST = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [CNT_W-1:0]  div_int = '0;
  logic [FRAC_W-1:0] div_frac = '0;
  logic              div_load = 1'b0;
  logic              sync = 1'b0;
  logic              os_tick;
  logic              bit_tick;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: the k-th tick after a restart falls on enabled cycle
  // k*D + floor(k*F / 2^FRAC_W); bit ticks on every OVS-th tick from a base phase.
  int   mD, mF, m_en, m_k, m_base;
  logic exp_os = 1'b0;
  logic exp_bit = 1'b0;

  baud_tick_gen #(
    .CNT_W(CNT_W), .FRAC_W(FRAC_W), .OVS(OVS),
    .DIV_RST(DIV_RST), .FRAC_RST(FRAC_RST)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .div_int(div_int), .div_frac(div_frac),
    .div_load(div_load), .sync(sync), .os_tick(os_tick), .bit_tick(bit_tick)
  );

  always #5 clk = ~clk;

  task automatic step(input logic a_rst, input logic a_en, input logic a_load,
                      input logic a_sync, input int a_di, input int a_df);
    rst = a_rst; en = a_en; div_load = a_load; sync = a_sync;
    div_int = CNT_W'(a_di); div_frac = FRAC_W'(a_df);
    exp_os = 1'b0; exp_bit = 1'b0;
    if (a_rst) begin
      mD = DIV_RST; mF = FRAC_RST; m_en = 0; m_k = 0; m_base = 0;
    end else if (a_load || a_sync) begin
      if (a_load) begin
        mD = (a_di < 2) ? 2 : a_di;
        mF = a_df;
      end
      m_en = 0; m_k = 0; m_base = a_sync ? OVS / 2 : 0;
    end else if (a_en) begin
      m_en++;
      if (m_en == (m_k + 1) * mD + (((m_k + 1) * mF) >> FRAC_W)) begin
        m_k++;
        exp_os  = 1'b1;
        exp_bit = ((m_k + m_base) % OVS) == 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    int per[$];
    int tbl[16];
    int last, t0, b1, b2;
    tbl = '{40, 41, 41, 40, 41, 41, 40, 41, 41, 40, 41, 41, 40, 41, 41, 41};
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0, 0);
      checks++;
      if (os_tick !== 1'b0 || bit_tick !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs os=%b bit=%b expected 0 0", os_tick, bit_tick);
      end
    end
    t0 = cyc; last = t0; b1 = -1; b2 = -1;
    for (int i = 0; i < 1310; i++) begin
      step(0, 1, 0, 0, 0, 0);
      checks++;
      if (os_tick !== exp_os || bit_tick !== exp_bit) begin
        errors++;
        $display("FAIL reset_seq cyc=%0d os=%b exp=%b bit=%b exp=%b", cyc, os_tick, exp_os, bit_tick, exp_bit);
      end
      if (os_tick === 1'b1) begin per.push_back(cyc - last); last = cyc; end
      if (bit_tick === 1'b1) begin
        if (b1 < 0) b1 = cyc - t0;
        else if (b2 < 0) b2 = cyc - t0;
      end
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (per.size() <= i || per[i] != tbl[i]) begin
        errors++;
        $display("FAIL reset_period[%0d] got=%0d expected=%0d", i, (per.size() > i) ? per[i] : -1, tbl[i]);
      end
    end
    checks++;
    if (b1 != 651) begin errors++; $display("FAIL reset_first_bit got=%0d expected=651", b1); end
    checks++;
    if (b2 != 1302) begin errors++; $display("FAIL reset_second_bit got=%0d expected=1302", b2); end
  endtask

  task automatic test_integer();
    int last, lastb, nb;
    step(0, 1, 1, 0, 10, 0);
    checks++;
    if (os_tick !== 1'b0 || bit_tick !== 1'b0) begin
      errors++;
      $display("FAIL int_load_cycle os=%b bit=%b expected 0 0", os_tick, bit_tick);
    end
    last = cyc; lastb = cyc; nb = 0;
    for (int i = 0; i < 340; i++) begin
      step(0, 1, 0, 0, 0, 0);
      checks++;
      if (os_tick !== exp_os || bit_tick !== exp_bit) begin
        errors++;
        $display("FAIL int_seq cyc=%0d os=%b exp=%b bit=%b exp=%b", cyc, os_tick, exp_os, bit_tick, exp_bit);
      end
      if (os_tick === 1'b1) begin
        checks++;
        if (cyc - last != 10) begin errors++; $display("FAIL int_os_period got=%0d expected=10", cyc - last); end
        last = cyc;
      end
      if (bit_tick === 1'b1) begin
        checks++;
        if (cyc - lastb != 160) begin errors++; $display("FAIL int_bit_period got=%0d expected=160", cyc - lastb); end
        lastb = cyc; nb++;
      end
    end
    checks++;
    if (nb != 2) begin errors++; $display("FAIL int_bit_count got=%0d expected=2", nb); end
  endtask

  task automatic test_sync();
    int n, ts, lat;
    bit found;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(0, 1, 0, 0, 0, 0);
      checks++;
      if (os_tick !== exp_os || bit_tick !== exp_bit) begin
        errors++;
        $display("FAIL sync_pre cyc=%0d os=%b exp=%b bit=%b exp=%b", cyc, os_tick, exp_os, bit_tick, exp_bit);
      end
      if (bit_tick === 1'b1) found = 1;
    end
    n = 0;
    for (int i = 0; i < 100 && n < 5; i++) begin
      step(0, 1, 0, 0, 0, 0);
      if (os_tick === 1'b1) n++;
    end
    checks++;
    if (!found || n != 5) begin errors++; $display("FAIL sync_setup found=%0d ticks=%0d expected 1 5", found, n); end
    step(0, 1, 0, 1, 0, 0);
    ts = cyc; lat = -1;
    for (int i = 0; i < 300 && lat < 0; i++) begin
      step(0, 1, 0, 0, 0, 0);
      checks++;
      if (os_tick !== exp_os || bit_tick !== exp_bit) begin
        errors++;
        $display("FAIL sync_seq cyc=%0d os=%b exp=%b bit=%b exp=%b", cyc, os_tick, exp_os, bit_tick, exp_bit);
      end
      if (bit_tick === 1'b1) lat = cyc - ts;
    end
    checks++;
    if (lat != 80) begin errors++; $display("FAIL sync_first_bit got=%0d expected=80", lat); end
    ts = cyc; lat = -1;
    for (int i = 0; i < 300 && lat < 0; i++) begin
      step(0, 1, 0, 0, 0, 0);
      if (bit_tick === 1'b1) lat = cyc - ts;
    end
    checks++;
    if (lat != 160) begin errors++; $display("FAIL sync_next_bit got=%0d expected=160", lat); end
    step(0, 1, 1, 1, 20, 0);
    ts = cyc; lat = -1;
    for (int i = 0; i < 400 && lat < 0; i++) begin
      step(0, 1, 0, 0, 0, 0);
      checks++;
      if (os_tick !== exp_os || bit_tick !== exp_bit) begin
        errors++;
        $display("FAIL sync_load_seq cyc=%0d os=%b exp=%b bit=%b exp=%b", cyc, os_tick, exp_os, bit_tick, exp_bit);
      end
      if (bit_tick === 1'b1) lat = cyc - ts;
    end
    checks++;
    if (lat != 160) begin errors++; $display("FAIL sync_load_bit got=%0d expected=160", lat); end
  endtask

  task automatic test_enable_clamp();
    int ts, lat, last;
    step(0, 1, 1, 0, 20, 0);
    ts = cyc;
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, 0, 0, 0);
      checks++;
      if (os_tick !== 1'b0 || bit_tick !== 1'b0) begin
        errors++;
        $display("FAIL en_low_outputs os=%b bit=%b expected 0 0", os_tick, bit_tick);
      end
    end
    lat = -1;
    for (int i = 0; i < 50 && lat < 0; i++) begin
      step(0, 1, 0, 0, 0, 0);
      checks++;
      if (os_tick !== exp_os || bit_tick !== exp_bit) begin
        errors++;
        $display("FAIL en_seq cyc=%0d os=%b exp=%b bit=%b exp=%b", cyc, os_tick, exp_os, bit_tick, exp_bit);
      end
      if (os_tick === 1'b1) lat = cyc - ts;
    end
    checks++;
    if (lat != 27) begin errors++; $display("FAIL en_delayed_tick got=%0d expected=27", lat); end
    for (int d = 0; d < 2; d++) begin
      step(0, 1, 1, 0, d, 0);
      last = cyc;
      for (int i = 0; i < 10; i++) begin
        step(0, 1, 0, 0, 0, 0);
        checks++;
        if (os_tick !== exp_os || (os_tick === 1'b1 && cyc - last != 2)) begin
          errors++;
          $display("FAIL clamp_div%0d cyc=%0d os=%b exp=%b", d, cyc, os_tick, exp_os);
        end
        if (os_tick === 1'b1) last = cyc;
      end
      checks++;
      if (cyc - last > 1) begin errors++; $display("FAIL clamp_period_div%0d gap=%0d expected<=1", d, cyc - last); end
    end
  endtask

  task automatic test_reset_mid();
    int tr, lat;
    bit found;
    step(1, 1, 0, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 700 && !found; i++) begin
      step(0, 1, 0, 0, 0, 0);
      if (bit_tick === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_wait got=0 expected=1"); end
    for (int i = 0; i < 650; i++) begin
      step(0, 1, 0, 0, 0, 0);
      checks++;
      if (os_tick !== exp_os || bit_tick !== exp_bit) begin
        errors++;
        $display("FAIL rstmid_seq cyc=%0d os=%b exp=%b bit=%b exp=%b", cyc, os_tick, exp_os, bit_tick, exp_bit);
      end
    end
    step(1, 1, 0, 0, 0, 0);
    checks++;
    if (os_tick !== 1'b0 || bit_tick !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_discard os=%b bit=%b expected 0 0", os_tick, bit_tick);
    end
    tr = cyc; lat = -1;
    for (int i = 0; i < 700 && lat < 0; i++) begin
      step(0, 1, 0, 0, 0, 0);
      checks++;
      if (os_tick !== exp_os || bit_tick !== exp_bit) begin
        errors++;
        $display("FAIL rstmid_restart cyc=%0d os=%b exp=%b bit=%b exp=%b", cyc, os_tick, exp_os, bit_tick, exp_bit);
      end
      if (bit_tick === 1'b1) lat = cyc - tr;
    end
    checks++;
    if (lat != 651) begin errors++; $display("FAIL rstmid_first_bit got=%0d expected=651", lat); end
  endtask

  task automatic test_random();
    int r;
    logic a_rst, a_en, a_load, a_sync;
    step(0, 1, 1, 0, 3, 5);
    for (int i = 0; i < 4000; i++) begin
      r      = int'($urandom_range(0, 999));
      a_rst  = (r == 0);
      a_load = (r >= 1 && r <= 5);
      a_sync = (r >= 6 && r <= 12);
      a_en   = ($urandom_range(0, 7) != 0);
      step(a_rst, a_en, a_load, a_sync, int'($urandom_range(0, 12)), int'($urandom_range(0, 15)));
      checks++;
      if (os_tick !== exp_os || bit_tick !== exp_bit) begin
        errors++;
        $display("FAIL random cyc=%0d os=%b exp=%b bit=%b exp=%b", cyc, os_tick, exp_os, bit_tick, exp_bit);
      end
    end
  endtask

  initial begin
    test_reset();
    test_integer();
    test_sync();
    test_enable_clamp();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
